// File: rtl/chacha20_pio_status_in.sv
`default_nettype none
// ============================================================================
// Module     : chacha20_pio_status_in
// Description: Avalon-MM input PIO with edge capture, irq mask and one irq.
//              Define CHACHA20_PIO_IN_SYNC_EN for a 2-flop input synchronizer.
// Revision   : 1.0 - initial release
// ============================================================================
module chacha20_pio_status_in #(
  parameter int WIDTH     = 2,
  parameter int EDGE_TYPE = 0,
  parameter int IRQ_MODE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [1:0]       arm_cnt_q;
  logic             armed_q;
  logic             irq_q;
  logic             irq_d;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_clr;
  logic             w_unused_wdata;

`ifdef CHACHA20_PIO_IN_SYNC_EN
  localparam logic [1:0] ARM_LAST = 2'd2;
  logic [WIDTH-1:0] s1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s1_q <= '0;
    else          s1_q <= in_port;
  end

  assign s1 = s1_q;
`else
  localparam logic [1:0] ARM_LAST = 2'd1;
  assign s1 = in_port;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      prev_q <= '0;
    end else begin
      data_q <= s1;
      prev_q <= data_q;
    end
  end

  // armed_q lags the saturated counter by one cycle so the first compare of
  // real samples against reset zeros in prev_q can never register an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= 2'd0;
      armed_q   <= 1'b0;
    end else begin
      if (arm_cnt_q != ARM_LAST) arm_cnt_q <= arm_cnt_q + 2'd1;
      armed_q <= (arm_cnt_q == ARM_LAST);
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = data_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~data_q & prev_q;
    end else begin : g_any
      assign edge_raw = data_q ^ prev_q;
    end
  endgenerate

  assign edge_det = armed_q ? edge_raw : '0;

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en & (address == 2'd2);
  assign wr_clr  = wr_en & (address == 2'd3);

  assign clr_mask  = wr_clr ? writedata[WIDTH-1:0] : '0;
  assign edgecap_d = (edgecap_q & ~clr_mask) | edge_det;

  generate
    if (IRQ_MODE == 0) begin : g_irq_edge
      assign irq_d = |(edgecap_q & irqmask_q);
    end else begin : g_irq_level
      assign irq_d = |(data_q & irqmask_q);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_mask) irqmask_q <= writedata[WIDTH-1:0];
      edgecap_q <= edgecap_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = data_q;
      2'd2:    readdata[WIDTH-1:0] = irqmask_q;
      2'd3:    readdata[WIDTH-1:0] = edgecap_q;
      default: readdata = '0;
    endcase
  end

  assign w_unused_wdata = ^writedata;

endmodule
`default_nettype wire

// File: tb/tb_chacha20_pio_status_in.sv
`default_nettype none
// Directed bench for chacha20_pio_status_in: one rising-edge instance with
// edge irq, one any-edge instance sharing the bus with its own chipselect.
module tb_chacha20_pio_status_in;
`ifdef CHACHA20_PIO_IN_SYNC_EN
  localparam int L = 1;
`else
  localparam int L = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs0, cs2, write_n;
  logic [31:0] writedata;
  logic [1:0]  in_port;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  chacha20_pio_status_in #(.WIDTH(2), .EDGE_TYPE(0), .IRQ_MODE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0));

  chacha20_pio_status_in #(.WIDTH(2), .EDGE_TYPE(2), .IRQ_MODE(0)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2));

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_wr(input logic sel_any, input logic [1:0] a, input logic [31:0] d);
    cs0 = ~sel_any; cs2 = sel_any; address = a; writedata = d; write_n = 1'b0;
    tick(1);
    cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1; writedata = 32'h0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; in_port = 2'b11; cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
    writedata = 32'h0; address = 2'd0;
    tick(3);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected %h", rd0, 32'h0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq0); end
    @(negedge clk); reset_n = 1'b1;
    tick(10);
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL arm_ec: got %h expected %h", rd0, 32'h0); end
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL arm_ec_any: got %h expected %h", rd2, 32'h0); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL arm_irq: got %b expected 0", irq0); end
    address = 2'd0; #1;
    checks++; if (rd0 !== 32'h3) begin errors++; $display("FAIL arm_data: got %h expected %h", rd0, 32'h3); end
  endtask

  task automatic test_capture;
    in_port = 2'b10;
    tick(4);
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL fall_ignored: got %h expected %h", rd0, 32'h0); end
    bus_wr(1'b0, 2'd2, 32'h1);
    address = 2'd2; #1;
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL irqmask_rd: got %h expected %h", rd0, 32'h1); end
    address = 2'd3;
    in_port = 2'b11;
    tick(1 + L);
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL ec_early: got %h expected %h", rd0, 32'h0); end
    tick(1);
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL ec_set: got %h expected %h", rd0, 32'h1); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_early: got %b expected 0", irq0); end
    tick(1);
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_set: got %b expected 1", irq0); end
  endtask

  task automatic test_clear;
    bus_wr(1'b0, 2'd3, 32'h1);
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL ec_clear: got %h expected %h", rd0, 32'h0); end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b expected 1", irq0); end
    tick(1);
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq0); end
  endtask

  task automatic test_set_wins;
    in_port = 2'b10;
    tick(4);
    address = 2'd3; #1;
    in_port = 2'b11;
    tick(3 + L);
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL recapture: got %h expected %h", rd0, 32'h1); end
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL reirq: got %b expected 1", irq0); end
    in_port = 2'b10;
    tick(4);
    in_port = 2'b11;
    tick(1 + L);
    bus_wr(1'b0, 2'd3, 32'h1);
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL set_wins_ec: got %h expected %h", rd0, 32'h1); end
    tick(1);
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL set_wins_irq: got %b expected 1", irq0); end
  endtask

  task automatic test_any_edge;
    in_port = 2'b01;
    tick(4);
    bus_wr(1'b1, 2'd3, 32'h3);
    address = 2'd3; #1;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL any_pre_clear: got %h expected %h", rd2, 32'h0); end
    in_port = 2'b11;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) in_port = 2'b01;
      tick(1);
      checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_irq_masked: cycle %0d got %b expected 0", i, irq2); end
    end
    checks++; if (rd2 !== 32'h2) begin errors++; $display("FAIL any_ec: got %h expected %h", rd2, 32'h2); end
    checks++; if (rd0 !== 32'h3) begin errors++; $display("FAIL rise_ec_bit1: got %h expected %h", rd0, 32'h3); end
    bus_wr(1'b1, 2'd3, 32'h2);
    address = 2'd3; #1;
    checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL any_clear: got %h expected %h", rd2, 32'h0); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL any_irq_end: got %b expected 0", irq2); end
  endtask

  task automatic test_reset_mid;
    checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b expected 1", irq0); end
    reset_n = 1'b0; #1;
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL async_irq: got %b expected 0", irq0); end
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL async_ec: got %h expected %h", rd0, 32'h0); end
    address = 2'd2; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL async_mask: got %h expected %h", rd0, 32'h0); end
    tick(2);
    reset_n = 1'b1;
    tick(6);
    bus_wr(1'b0, 2'd0, 32'hFFFF_FFFF);
    bus_wr(1'b0, 2'd1, 32'hFFFF_FFFF);
    tick(2);
    address = 2'd1; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rsvd_rd: got %h expected %h", rd0, 32'h0); end
    address = 2'd2; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL wr0_mask: got %h expected %h", rd0, 32'h0); end
    address = 2'd3; #1;
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL wr0_ec: got %h expected %h", rd0, 32'h0); end
    address = 2'd0; #1;
    checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL wr0_data: got %h expected %h", rd0, 32'h1); end
    checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL wr0_irq: got %b expected 0", irq0); end
  endtask

  initial begin
    test_reset;
    test_capture;
    test_clear;
    test_set_wins;
    test_any_edge;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
